// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory-port arbiter.
// Optional round-robin arbitration is enabled with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant selection between the instruction and data requesters.
// Fixed D-over-I priority by default; round-robin when MEM_ARB_RR_EN is defined.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   i_d_req,
`ifdef MEM_ARB_RR_EN
  input  owner_t i_last_grant,
`endif
  output logic   o_valid,
  output owner_t o_owner
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_valid = i_req | i_d_req;
    o_owner = i_d_req ? OWN_D : OWN_I;
`ifdef MEM_ARB_RR_EN
    if (i_req && i_d_req) begin
      o_owner = (i_last_grant == OWN_I) ? OWN_D : OWN_I;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D),
// holding each access for LATENCY cycles. MEM_ARB_RR_EN selects round-robin grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  owner_t           r_owner;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_write;
  logic [31:0]      r_i_rdata;
  logic [31:0]      r_d_rdata;
  logic             w_grant_valid;
  owner_t           w_grant_owner;
  logic             w_access;
  logic             w_last;

`ifdef MEM_ARB_RR_EN
  owner_t r_last_grant;
`endif

  mem_arb_grant u_grant (
    .i_req        (i_req),
    .i_d_req      (d_req),
`ifdef MEM_ARB_RR_EN
    .i_last_grant (r_last_grant),
`endif
    .o_valid      (w_grant_valid),
    .o_owner      (w_grant_owner)
  );

  assign w_access = (r_state == ACCESS);
  assign w_last   = (r_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_state_next = ACCESS;
      ACCESS:  if (w_last)        w_state_next = DONE;
      DONE:                       w_state_next = IDLE;
      default:                    w_state_next = IDLE;
    endcase
  end

  // Request fields are captured only in IDLE, so requester changes mid-transaction are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_owner   <= OWN_I;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_grant <= OWN_I;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_grant_valid) begin
          r_owner <= w_grant_owner;
          r_addr  <= (w_grant_owner == OWN_D) ? d_addr : i_addr;
          r_write <= (w_grant_owner == OWN_D) && d_write;
          r_wdata <= (w_grant_owner == OWN_D) ? d_wdata : '0;
          r_cnt   <= CNT_W'(LATENCY - 1);
`ifdef MEM_ARB_RR_EN
          r_last_grant <= w_grant_owner;
`endif
        end
        ACCESS: begin
          if (!w_last) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (!r_write) begin
            if (r_owner == OWN_I) r_i_rdata <= mem_dout;
            else                  r_d_rdata <= mem_dout;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = w_access ? r_addr  : '0;
  assign mem_din   = w_access ? r_wdata : '0;
  assign mem_read  = w_access && !r_write;
  assign mem_write = w_access && r_write && w_last;
  assign i_ready   = (r_state == DONE) && (r_owner == OWN_I);
  assign d_ready   = (r_state == DONE) && (r_owner == OWN_D);
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != IDLE);

endmodule
